// File: rtl/mult_pkg.sv
// Shared multiplier definitions: FSM state encoding and a constant-safe clog2.
package mult_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'b00;
  localparam state_t S_SHIFT = 2'b01;
  localparam state_t S_DONE  = 2'b10;

  // Number of bits needed to index v distinct values; usable in parameter defaults.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/mult_operand_serializer_bit_counter_sat.sv
// Up-counter with synchronous clear and enable that sticks at MAX instead of wrapping.
module bit_counter_sat #(
  parameter int CW  = 4,
  parameter int MAX = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] cnt
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr)                                cnt <= '0;
    else if (clear)                         cnt <= '0;
    else if (en && (cnt != CW'(MAX)))       cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/mult_operand_serializer.sv
// Parallel-in, serial-out multiplier operand register with bit counter and done flag.
// Define MULT_SER_EARLY_TERM_EN to finish as soon as the remaining operand bits are zero.
module mult_operand_serializer
  import mult_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = clog2(N + 1)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic [N-1:0]  D,
  input  logic          step,
  output logic          lsb,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cnt,
  output logic          rem_zero
);

  state_t       state;
  logic [N-1:0] r_reg;
  logic [N-1:0] shifted;
  logic         load;
  logic         adv;
  logic         last;

  assign load    = start && ((state == S_IDLE) || (state == S_DONE));
  assign adv     = step && (state == S_SHIFT);
  assign shifted = r_reg >> 1;

`ifdef MULT_SER_EARLY_TERM_EN
  assign last = (cnt == CW'(N - 1)) || (shifted == '0);
`else
  assign last = (cnt == CW'(N - 1));
`endif

  bit_counter_sat #(.CW(CW), .MAX(N)) u_cnt (
    .clk   (clk),
    .clr   (clr),
    .clear (load),
    .en    (adv),
    .cnt   (cnt)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
      r_reg <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // start outranks a simultaneous step here
          if (start) begin
            r_reg <= D;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (step) begin
            r_reg <= shifted;
            if (last) state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign lsb      = r_reg[0];
  assign busy     = (state == S_SHIFT);
  assign done     = (state == S_DONE);
  assign rem_zero = (r_reg == '0);

endmodule

// File: tb/tb_mult_operand_serializer.sv
// Randomized self-checking bench for mult_operand_serializer against an operand/count model.
module tb_mult_operand_serializer;

  localparam int N  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  D = '0;
  logic          step = 1'b0;
  logic          lsb, busy, done, rem_zero;
  logic [CW-1:0] cnt;

  int checks = 0;
  int errors = 0;

  // Model: the loaded operand, how many bits were consumed, and a phase (0 idle, 1 shifting, 2 done).
  logic [N-1:0] m_op;
  int           m_cnt;
  int           m_ph;

`ifdef MULT_SER_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  mult_operand_serializer #(.N(N), .CW(CW)) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .D        (D),
    .step     (step),
    .lsb      (lsb),
    .busy     (busy),
    .done     (done),
    .cnt      (cnt),
    .rem_zero (rem_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [4+CW-1:0] exp_vec();
    logic [N-1:0] rem;
    rem = m_op >> m_cnt;
    return {rem[0], m_ph == 1, m_ph == 2, rem == '0, CW'(m_cnt)};
  endfunction

  function automatic logic [4+CW-1:0] obs_vec();
    return {lsb, busy, done, rem_zero, cnt};
  endfunction

  task automatic model_reset();
    m_op = '0; m_cnt = 0; m_ph = 0;
  endtask

  // Drive one cycle of inputs, clock it, advance the model, settle for sampling.
  task automatic drive(input bit st, input bit sp, input logic [N-1:0] d);
    start = st; step = sp; D = d;
    @(posedge clk);
    if (st && m_ph != 1) begin
      m_op = d; m_cnt = 0; m_ph = 1;
    end else if (sp && m_ph == 1) begin
      m_cnt++;
      if (m_cnt == N || (EARLY && ((m_op >> m_cnt) == '0))) m_ph = 2;
    end
    #1;
    start = 0; step = 0;
  endtask

  task automatic test_reset();
    clr = 1; model_reset();
    #12;
    checks++;
    if (obs_vec() !== 8'b0001_0000) begin
      errors++; $display("FAIL reset_initial got %b want %b", obs_vec(), 8'b0001_0000);
    end
    @(negedge clk); clr = 0;
    drive(1, 0, 8'hA5);
    for (int i = 0; i < 3; i++) drive(0, 1, '0);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL pre_clr got %b want %b", obs_vec(), exp_vec());
    end
    #2 clr = 1; model_reset();
    #1;
    checks++;
    if (obs_vec() !== 8'b0001_0000) begin
      errors++; $display("FAIL clr_mid_shift got %b want %b", obs_vec(), 8'b0001_0000);
    end
    #1 clr = 0;
  endtask

  task automatic test_full();
    logic [N-1:0] seq;
    seq = 8'hA5;
    drive(1, 0, 8'hA5);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (lsb !== seq[i] || obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL full_step%0d got %b want %b lsb_want %b", i, obs_vec(), exp_vec(), seq[i]);
      end
      drive(0, 1, '0);
    end
    checks++;
    if (done !== 1'b1 || cnt !== CW'(8) || busy !== 1'b0) begin
      errors++; $display("FAIL full_done got done=%b cnt=%0d busy=%b want 1 8 0", done, cnt, busy);
    end
  endtask

  task automatic test_gaps();
    drive(1, 0, 8'h81);
    for (int i = 0; i < 2 * N; i++) begin
      drive(0, (i % 2) == 0, '0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL gaps_cyc%0d got %b want %b", i, obs_vec(), exp_vec());
      end
      if (i < 2 * N - 2 && done !== 1'b0) begin
        errors++; checks++; $display("FAIL gaps_early_done cyc%0d got 1 want 0", i);
      end
    end
  endtask

  task automatic test_ignored();
    drive(1, 0, 8'h3C);
    drive(0, 1, '0);
    drive(1, 0, 8'hFF);
    checks++;
    if (obs_vec() !== exp_vec() || cnt !== CW'(1) || lsb !== 1'b0) begin
      errors++; $display("FAIL start_in_shift got %b want %b", obs_vec(), exp_vec());
    end
    clr = 1; #1 clr = 0; model_reset();
    drive(0, 1, '0);
    checks++;
    if (obs_vec() !== 8'b0001_0000) begin
      errors++; $display("FAIL step_in_idle got %b want %b", obs_vec(), 8'b0001_0000);
    end
    drive(1, 0, 8'hF0);
    for (int i = 0; i < N; i++) drive(0, 1, '0);
    drive(1, 1, 8'h77);
    checks++;
    if (obs_vec() !== exp_vec() || cnt !== '0 || busy !== 1'b1 || lsb !== 1'b1) begin
      errors++; $display("FAIL start_step_done got %b want %b", obs_vec(), exp_vec());
    end
    for (int i = 0; i < N; i++) drive(0, 1, '0);
  endtask

  task automatic test_early();
    int steps;
    steps = 0;
    drive(1, 0, 8'h03);
    while (!done && steps < N + 2) begin
      drive(0, 1, '0);
      steps++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL early_step%0d got %b want %b", steps, obs_vec(), exp_vec());
      end
      if (cnt >= CW'(2) && rem_zero !== 1'b1) begin
        errors++; checks++; $display("FAIL early_rem_zero cnt=%0d got 0 want 1", cnt);
      end
    end
    checks++;
    if (steps != (EARLY ? 2 : N) || cnt !== CW'(EARLY ? 2 : N)) begin
      errors++; $display("FAIL early_len got steps=%0d cnt=%0d want %0d", steps, cnt, EARLY ? 2 : N);
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 8'h5A);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || lsb !== 1'b0 || cnt !== '0) begin
      errors++; $display("FAIL b2b got busy=%b done=%b lsb=%b cnt=%0d want 1 0 0 0", busy, done, lsb, cnt);
    end
    for (int i = 0; i < N; i++) drive(0, 1, '0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0, N'($urandom));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_cyc%0d got %b want %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full();
    test_gaps();
    test_ignored();
    test_early();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
